time_set_controller: RTL and testbench
======================================

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 Parameter BLINK_TICKS, default 25, tick100 pulses per blink half-period (2 Hz blink).
REQ-002 Parameter TIMEOUT_TICKS, default 1000, tick100 pulses without a key press before edit aborts (10 s).
REQ-003 Parameter HOLD_TICKS, default 50, tick100 pulses a key is held before auto-repeat starts.
REQ-004 Parameter REPEAT_TICKS, default 10, tick100 pulses between auto-repeat pulses.
REQ-005 clk  input  1  system clock, 100 MHz.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 tick100  input  1  100 Hz clock enable, one clk cycle wide.
REQ-008 btn_set, btn_up, btn_down, btn_left, btn_right  input  1 each  debounced key levels, 1 = pressed.
REQ-009 cur_hh, cur_mm, cur_ss  input  8 each  current time, packed BCD.
REQ-010 set_hh, set_mm, set_ss  output  8 each  edited time, packed BCD, registered.
REQ-011 ld  output  1  one-cycle load strobe for the timer datapath.
REQ-012 editing  output  1  high while in EDIT.
REQ-013 sel  output  2  selected field: 0 = SS, 1 = MM, 2 = HH; 3 never driven.
REQ-014 blink  output  1  display blank phase for the selected field; 1 = show.

Function
REQ-015 Each key SHALL generate a one-clk press pulse on its rising edge; all actions below are triggered by press pulses only.
REQ-016 The FSM SHALL have the states IDLE, EDIT and COMMIT.
REQ-017 IDLE + set press: set_* <= cur_*, sel <= 2, timeout counter cleared, next state EDIT; all other keys ignored.
REQ-018 EDIT + up: selected field +1 in BCD; HH wraps 23->00, MM/SS wrap 59->00.
REQ-019 EDIT + down: selected field -1 in BCD; HH 00->23, MM/SS 00->59.
REQ-020 EDIT + left: sel SS->MM->HH->SS; right: sel HH->MM->SS->HH.
REQ-021 EDIT + set: next state COMMIT with set_* unchanged.
REQ-022 COMMIT: ld = 1 for exactly one cycle with set_* stable, then IDLE; ld SHALL be 0 in all other cycles.
REQ-023 Simultaneous presses: priority set > up > down > left > right; exactly one action per cycle.
REQ-024 The timeout counter SHALL count tick100 in EDIT, clear on any press pulse, and on reaching TIMEOUT_TICKS return to IDLE with no ld (abort).
REQ-025 blink SHALL toggle every BLINK_TICKS ticks in EDIT, be forced to 1 on EDIT entry and on any press, and be 0 in IDLE/COMMIT.
REQ-026 set_* SHALL always hold valid in-range BCD; set_* SHALL hold their last values in IDLE.
REQ-027 editing = 1 exactly when state is EDIT.

Reset
REQ-028 On rst: state IDLE; set_* = 8'h00; sel = 0; ld, editing, blink = 0; all counters and edge registers cleared.
REQ-029 rst asserted mid-edit SHALL discard the edit with no ld pulse.

Configuration
REQ-030 With TIME_SET_AUTO_REPEAT_EN defined: up/down held continuously SHALL emit an extra press pulse after HOLD_TICKS ticks, then every REPEAT_TICKS ticks until release.
REQ-031 Without TIME_SET_AUTO_REPEAT_EN: exactly one press pulse per key press; no hold counters are instantiated.

Structure
REQ-032 The shared package SHALL hold the state enum (IDLE/EDIT/COMMIT), sel encodings, and BCD limits 8'h23 / 8'h59.
REQ-033 One sub-module, key_pulse, SHALL implement per-key edge detection plus the optional auto-repeat; it is instantiated five times.

Verification
REQ-034 cur = 12:34:56, set press, 12 up presses on HH, set press -> ld single cycle with set = 00:34:56.
REQ-035 In EDIT with SS = 00, down -> SS = 59; with HH = 00, down -> HH = 23.
REQ-036 Enter EDIT (sel = 2), left -> sel = 0, right -> sel = 2, right -> sel = 1.
REQ-037 Enter EDIT, then no presses for 1000 ticks -> editing = 0, ld never asserted; rst mid-edit -> same outcome, outputs at reset values.
REQ-038 In EDIT, set and up pressed in the same cycle -> COMMIT with unchanged value; ld asserted once.
REQ-039 Up held for 75 ticks on SS = 00 -> SS = 04 with TIME_SET_AUTO_REPEAT_EN; SS = 01 without.

Source files
------------

// File: rtl/time_set_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : time_set_controller_pkg
// Purpose  : Shared types, encodings and BCD helpers for the time-set editor.
// Revision : 1.0 - initial release
// ============================================================================
package time_set_controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [1:0] C_SEL_SS = 2'd0;
    localparam logic [1:0] C_SEL_MM = 2'd1;
    localparam logic [1:0] C_SEL_HH = 2'd2;

    localparam logic [7:0] C_HH_MAX = 8'h23;
    localparam logic [7:0] C_MS_MAX = 8'h59;

    localparam int C_KEY_RIGHT = 0;
    localparam int C_KEY_LEFT  = 1;
    localparam int C_KEY_DOWN  = 2;
    localparam int C_KEY_UP    = 3;
    localparam int C_KEY_SET   = 4;
    localparam int C_NUM_KEYS  = 5;

    // Out-of-range inputs fold onto the wrap value so the result is always legal.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v >= max)
            return 8'h00;
        else if (v[3:0] >= 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00 || v > max)
            return max;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : time_set_controller_if
// Purpose  : Key, current-time and edited-time bundle of the time-set editor.
// Revision : 1.0 - initial release
// ============================================================================
interface time_set_controller_if;
    logic       tick100;
    logic       btn_set;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [7:0] cur_hh;
    logic [7:0] cur_mm;
    logic [7:0] cur_ss;
    logic [7:0] set_hh;
    logic [7:0] set_mm;
    logic [7:0] set_ss;
    logic       ld;
    logic       editing;
    logic [1:0] sel;
    logic       blink;

    modport master (
        output tick100, btn_set, btn_up, btn_down, btn_left, btn_right,
        output cur_hh, cur_mm, cur_ss,
        input  set_hh, set_mm, set_ss, ld, editing, sel, blink
    );

    modport slave (
        input  tick100, btn_set, btn_up, btn_down, btn_left, btn_right,
        input  cur_hh, cur_mm, cur_ss,
        output set_hh, set_mm, set_ss, ld, editing, sel, blink
    );
endinterface
`default_nettype wire

// File: rtl/time_set_controller_key_pulse.sv
`default_nettype none
// ============================================================================
// Module   : key_pulse
// Purpose  : Rising-edge press pulse for one key, with optional hold-to-repeat
//            when TIME_SET_AUTO_REPEAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module key_pulse #(
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 10,
    parameter bit REPEAT_EN    = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
`ifdef TIME_SET_AUTO_REPEAT_EN
    input  wire logic tick,
`endif
    input  wire logic key,
    output logic      pulse
);

    logic r_prev;
    logic r_pulse;
    logic w_rep_fire;

`ifdef TIME_SET_AUTO_REPEAT_EN
    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int CW = $clog2((HOLD_TICKS > REPEAT_TICKS ? HOLD_TICKS : REPEAT_TICKS) + 1);
            localparam logic [CW-1:0] C_HOLD_LAST   = CW'(HOLD_TICKS - 1);
            localparam logic [CW-1:0] C_REPEAT_LAST = CW'(REPEAT_TICKS - 1);

            logic [CW-1:0] r_cnt;
            logic          r_repeating;
            logic          w_held;

            assign w_held     = key & r_prev;
            assign w_rep_fire = w_held & tick &
                                (r_repeating ? (r_cnt == C_REPEAT_LAST) : (r_cnt == C_HOLD_LAST));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt       <= '0;
                    r_repeating <= 1'b0;
                end else if (!w_held) begin
                    r_cnt       <= '0;
                    r_repeating <= 1'b0;
                end else if (tick) begin
                    if (w_rep_fire) begin
                        r_cnt       <= '0;
                        r_repeating <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end
        end else begin : g_no_repeat
            assign w_rep_fire = 1'b0;
        end
    endgenerate
`else
    assign w_rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= key;
            r_pulse <= (key & ~r_prev) | w_rep_fire;
        end
    end

    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/time_set_controller.sv
`default_nettype none
// ============================================================================
// Module   : time_set_controller
// Purpose  : HH:MM:SS edit FSM with blink, timeout abort and one-cycle load
//            strobe. Optional auto-repeat: TIME_SET_AUTO_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
import time_set_controller_pkg::*;

module time_set_controller #(
    parameter int BLINK_TICKS   = 25,
    parameter int TIMEOUT_TICKS = 1000,
    parameter int HOLD_TICKS    = 50,
    parameter int REPEAT_TICKS  = 10
) (
    input wire logic              clk,
    input wire logic              rst,
    time_set_controller_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam logic [TW-1:0] C_TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [BW-1:0] C_BLINK_LAST   = BW'(BLINK_TICKS - 1);

    logic [C_NUM_KEYS-1:0] w_keys;
    logic [C_NUM_KEYS-1:0] w_press;

    state_t        r_state;
    logic [7:0]    r_hh, r_mm, r_ss;
    logic [1:0]    r_sel;
    logic          r_ld;
    logic          r_editing;
    logic          r_blink;
    logic [TW-1:0] r_tcnt;
    logic [BW-1:0] r_bcnt;

    assign w_keys[C_KEY_RIGHT] = bus.btn_right;
    assign w_keys[C_KEY_LEFT]  = bus.btn_left;
    assign w_keys[C_KEY_DOWN]  = bus.btn_down;
    assign w_keys[C_KEY_UP]    = bus.btn_up;
    assign w_keys[C_KEY_SET]   = bus.btn_set;

    generate
        for (genvar i = 0; i < C_NUM_KEYS; i++) begin : g_key
            key_pulse #(
                .HOLD_TICKS   (HOLD_TICKS),
                .REPEAT_TICKS (REPEAT_TICKS),
                .REPEAT_EN    (i == C_KEY_UP || i == C_KEY_DOWN)
            ) u_key_pulse (
                .clk   (clk),
                .rst   (rst),
`ifdef TIME_SET_AUTO_REPEAT_EN
                .tick  (bus.tick100),
`endif
                .key   (w_keys[i]),
                .pulse (w_press[i])
            );
        end
    endgenerate

    // Press pulses are mutually prioritised: set > up > down > left > right.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_hh      <= 8'h00;
            r_mm      <= 8'h00;
            r_ss      <= 8'h00;
            r_sel     <= C_SEL_SS;
            r_ld      <= 1'b0;
            r_editing <= 1'b0;
            r_blink   <= 1'b0;
            r_tcnt    <= '0;
            r_bcnt    <= '0;
        end else begin
            r_ld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_press[C_KEY_SET]) begin
                        r_hh      <= bus.cur_hh;
                        r_mm      <= bus.cur_mm;
                        r_ss      <= bus.cur_ss;
                        r_sel     <= C_SEL_HH;
                        r_tcnt    <= '0;
                        r_bcnt    <= '0;
                        r_blink   <= 1'b1;
                        r_editing <= 1'b1;
                        r_state   <= EDIT;
                    end
                end
                EDIT: begin
                    if (|w_press) begin
                        r_tcnt  <= '0;
                        r_bcnt  <= '0;
                        r_blink <= 1'b1;
                        if (w_press[C_KEY_SET]) begin
                            r_ld      <= 1'b1;
                            r_editing <= 1'b0;
                            r_blink   <= 1'b0;
                            r_state   <= COMMIT;
                        end else if (w_press[C_KEY_UP]) begin
                            case (r_sel)
                                C_SEL_SS: r_ss <= bcd_inc(r_ss, C_MS_MAX);
                                C_SEL_MM: r_mm <= bcd_inc(r_mm, C_MS_MAX);
                                C_SEL_HH: r_hh <= bcd_inc(r_hh, C_HH_MAX);
                                default:  r_sel <= C_SEL_SS;
                            endcase
                        end else if (w_press[C_KEY_DOWN]) begin
                            case (r_sel)
                                C_SEL_SS: r_ss <= bcd_dec(r_ss, C_MS_MAX);
                                C_SEL_MM: r_mm <= bcd_dec(r_mm, C_MS_MAX);
                                C_SEL_HH: r_hh <= bcd_dec(r_hh, C_HH_MAX);
                                default:  r_sel <= C_SEL_SS;
                            endcase
                        end else if (w_press[C_KEY_LEFT]) begin
                            r_sel <= (r_sel >= C_SEL_HH) ? C_SEL_SS : r_sel + 2'd1;
                        end else begin
                            r_sel <= (r_sel == C_SEL_SS || r_sel > C_SEL_HH) ? C_SEL_HH : r_sel - 2'd1;
                        end
                    end else if (bus.tick100) begin
                        if (r_tcnt == C_TIMEOUT_LAST) begin
                            r_tcnt    <= '0;
                            r_bcnt    <= '0;
                            r_editing <= 1'b0;
                            r_blink   <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                            if (r_bcnt == C_BLINK_LAST) begin
                                r_bcnt  <= '0;
                                r_blink <= ~r_blink;
                            end else begin
                                r_bcnt <= r_bcnt + BW'(1);
                            end
                        end
                    end
                end
                COMMIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_editing <= 1'b0;
                    r_blink   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.set_hh  = r_hh;
    assign bus.set_mm  = r_mm;
    assign bus.set_ss  = r_ss;
    assign bus.sel     = r_sel;
    assign bus.ld      = r_ld;
    assign bus.editing = r_editing;
    assign bus.blink   = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_time_set_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_set_controller
// Purpose  : Table-driven self-checking bench for time_set_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_set_controller;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    int   ld_cnt;
    logic ld_prev;

    time_set_controller_if bus ();

    time_set_controller #(
        .BLINK_TICKS   (25),
        .TIMEOUT_TICKS (1000),
        .HOLD_TICKS    (50),
        .REPEAT_TICKS  (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts strobe cycles; a double-wide strobe shows up as an extra count.
    always @(negedge clk) begin
        if (bus.ld) ld_cnt++;
        if (bus.ld && ld_prev) begin
            n_vec++;
            n_miss++;
            $display("FAIL ld_width: ld high for more than one cycle, required 1");
        end
        ld_prev = bus.ld;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "watchdog");
    end

    localparam logic [4:0] K_S = 5'b10000;
    localparam logic [4:0] K_U = 5'b01000;
    localparam logic [4:0] K_D = 5'b00100;
    localparam logic [4:0] K_L = 5'b00010;
    localparam logic [4:0] K_R = 5'b00001;
    localparam logic [4:0] K_N = 5'b00000;

    typedef struct {
        logic [4:0] keys;
        int         reps;
        int         ticks;
        logic [7:0] chh, cmm, css;
        logic       e_edit;
        logic [1:0] e_sel;
        logic [7:0] e_hh, e_mm, e_ss;
        int         e_ld;
    } vec_t;

    vec_t vecs[25];

    task automatic set_keys(input logic [4:0] k);
        {bus.btn_set, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = k;
    endtask

    task automatic press(input logic [4:0] k);
        @(negedge clk);
        set_keys(k);
        repeat (2) @(negedge clk);
        set_keys(K_N);
        repeat (2) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        bus.tick100 = 1'b1;
        @(negedge clk);
        bus.tick100 = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] snap();
        return {21'd0, bus.editing, bus.sel, bus.set_hh, bus.set_mm, bus.set_ss, 8'(ld_cnt)};
    endfunction

    function automatic vec_t mk(logic [4:0] k, int r, int t, logic [23:0] cur,
                                logic ed, logic [1:0] s, logic [23:0] set, int l);
        vec_t v;
        v.keys = k; v.reps = r; v.ticks = t;
        {v.chh, v.cmm, v.css} = cur;
        v.e_edit = ed; v.e_sel = s;
        {v.e_hh, v.e_mm, v.e_ss} = set;
        v.e_ld = l;
        return v;
    endfunction

    initial begin
        logic [63:0] exp_v;
        logic [7:0]  exp_rep_ss;
        int          ld_before;

        n_vec = 0; n_miss = 0; ld_cnt = 0; ld_prev = 1'b0;
        rst = 1'b1;
        bus.tick100 = 1'b0;
        set_keys(K_N);
        bus.cur_hh = 8'h12; bus.cur_mm = 8'h34; bus.cur_ss = 8'h56;

        //              keys     reps tick cur          ed sel set          ld
        vecs[0]  = mk(K_S,       1,  0, 24'h123456, 1, 2, 24'h123456, 0);
        vecs[1]  = mk(K_U,      11,  0, 24'h123456, 1, 2, 24'h233456, 0);
        vecs[2]  = mk(K_U,       1,  0, 24'h123456, 1, 2, 24'h003456, 0);
        vecs[3]  = mk(K_S,       1,  0, 24'h123456, 0, 2, 24'h003456, 1);
        vecs[4]  = mk(K_S,       1,  0, 24'h000000, 1, 2, 24'h000000, 1);
        vecs[5]  = mk(K_D,       1,  0, 24'h000000, 1, 2, 24'h230000, 1);
        vecs[6]  = mk(K_L,       1,  0, 24'h000000, 1, 0, 24'h230000, 1);
        vecs[7]  = mk(K_D,       1,  0, 24'h000000, 1, 0, 24'h230059, 1);
        vecs[8]  = mk(K_R,       1,  0, 24'h000000, 1, 2, 24'h230059, 1);
        vecs[9]  = mk(K_R,       1,  0, 24'h000000, 1, 1, 24'h230059, 1);
        vecs[10] = mk(K_U,       1,  0, 24'h000000, 1, 1, 24'h230159, 1);
        vecs[11] = mk(K_D,       1,  0, 24'h000000, 1, 1, 24'h230059, 1);
        vecs[12] = mk(K_D,       1,  0, 24'h000000, 1, 1, 24'h235959, 1);
        vecs[13] = mk(K_S | K_U, 1,  0, 24'h000000, 0, 1, 24'h235959, 2);
        vecs[14] = mk(K_S,       1,  0, 24'h235959, 1, 2, 24'h235959, 2);
        vecs[15] = mk(K_L,       1,  0, 24'h235959, 1, 0, 24'h235959, 2);
        vecs[16] = mk(K_U,       1,  0, 24'h235959, 1, 0, 24'h235900, 2);
        vecs[17] = mk(K_L,       1,  0, 24'h235959, 1, 1, 24'h235900, 2);
        vecs[18] = mk(K_U,       1,  0, 24'h235959, 1, 1, 24'h230000, 2);
        vecs[19] = mk(K_L,       1,  0, 24'h235959, 1, 2, 24'h230000, 2);
        vecs[20] = mk(K_U,       1,  0, 24'h235959, 1, 2, 24'h000000, 2);
        vecs[21] = mk(K_D,       1,  0, 24'h235959, 1, 2, 24'h230000, 2);
        vecs[22] = mk(K_N,       0, 999, 24'h235959, 1, 2, 24'h230000, 2);
        vecs[23] = mk(K_N,       0,  1, 24'h235959, 0, 2, 24'h230000, 2);
        vecs[24] = mk(K_U | K_R, 1,  0, 24'h111111, 0, 2, 24'h230000, 2);

        repeat (3) @(negedge clk);
        check("reset_state", {bus.editing, bus.sel, bus.ld, bus.blink, bus.set_hh, bus.set_mm, bus.set_ss},
              {1'b0, 2'd0, 1'b0, 1'b0, 24'h000000});
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            bus.cur_hh = vecs[i].chh; bus.cur_mm = vecs[i].cmm; bus.cur_ss = vecs[i].css;
            for (int r = 0; r < vecs[i].reps; r++) press(vecs[i].keys);
            for (int t = 0; t < vecs[i].ticks; t++) tick();
            @(negedge clk);
            exp_v = {21'd0, vecs[i].e_edit, vecs[i].e_sel, vecs[i].e_hh, vecs[i].e_mm, vecs[i].e_ss,
                     8'(vecs[i].e_ld)};
            check($sformatf("vec%0d", i), snap(), exp_v);
        end

        // Blink phase: forced on at entry, toggles after 25 ticks, re-forced by a press.
        press(K_S);
        check("blink_entry", {bus.editing, bus.blink}, 2'b11);
        repeat (24) tick();
        check("blink_24", bus.blink, 1'b1);
        tick();
        check("blink_25", bus.blink, 1'b0);
        press(K_L);
        check("blink_press", bus.blink, 1'b1);
        press(K_S);
        check("blink_commit", {bus.editing, bus.blink, 8'(ld_cnt)}, {2'b00, 8'd3});

        // Reset in the middle of an edit discards it without a strobe.
        press(K_S);
        check("rst_pre_edit", bus.editing, 1'b1);
        ld_before = ld_cnt;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_edit", {bus.editing, bus.sel, bus.ld, bus.blink, bus.set_hh, bus.set_mm, bus.set_ss},
              {1'b0, 2'd0, 1'b0, 1'b0, 24'h000000});
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_no_ld", 32'(ld_cnt), 32'(ld_before));

        // Up held for 75 ticks on SS = 00.
        bus.cur_hh = 8'h00; bus.cur_mm = 8'h00; bus.cur_ss = 8'h00;
        press(K_S);
        press(K_L);
        check("hold_sel", bus.sel, 2'd0);
        @(negedge clk);
        set_keys(K_U);
        repeat (2) @(negedge clk);
        repeat (75) tick();
        set_keys(K_N);
        repeat (3) @(negedge clk);
`ifdef TIME_SET_AUTO_REPEAT_EN
        exp_rep_ss = 8'h04;
`else
        exp_rep_ss = 8'h01;
`endif
        check("hold_up_ss", bus.set_ss, exp_rep_ss);
        press(K_S);
        check("hold_commit", {bus.editing, 8'(ld_cnt)}, {1'b0, 8'(ld_before + 1)});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
